// File: rtl/mips_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_pkg
// Description : Shared widths, state encodings and helpers for the iterative
//               MIPS DIV/DIVU unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;
    localparam int WorkBus      = 65;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [5:0] DivIterations = 6'd32;

    function automatic logic [RegBus-1:0] twos_neg(input logic [RegBus-1:0] v);
        return ~v + RegBus'(1);
    endfunction

endpackage : mips_div_pkg
`default_nettype wire

// File: rtl/mips_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_step
// Description : One radix-2 restoring iteration: shift the work register left,
//               trial-subtract the divisor from the upper part, set quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_div_step
    import mips_div_pkg::*;
(
    input  logic [WorkBus-1:0] work,
    input  logic [RegBus-1:0]  divisor,
    output logic [WorkBus-1:0] work_next
);

    // Upper 33 bits after the shift, plus one guard bit so the borrow lands in bit 33.
    logic [RegBus+1:0] w_hi;
    logic [RegBus+1:0] w_diff;

    assign w_hi   = work[WorkBus-1:RegBus-1];
    assign w_diff = w_hi - {2'b00, divisor};

    always_comb begin
        if (w_diff[RegBus+1]) begin
            work_next = {work[WorkBus-2:0], 1'b0};
        end else begin
            work_next = {w_diff[RegBus:0], work[RegBus-2:0], 1'b1};
        end
    end

endmodule : mips_div_step
`default_nettype wire

// File: rtl/mips_div.sv
`default_nettype none
// ============================================================================
// Module      : mips_div
// Description : Iterative 32-bit signed/unsigned divider for the EX stage,
//               returning {remainder, quotient} with a registered ready flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_div
    import mips_div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_t              r_state;
    div_state_t              w_state_nxt;
    logic [WorkBus-1:0]      r_work;
    logic [WorkBus-1:0]      w_work_nxt;
    logic [WorkBus-1:0]      w_work_step;
    logic [5:0]              r_cnt;
    logic [5:0]              w_cnt_nxt;
    logic [RegBus-1:0]       r_divisor;
    logic [RegBus-1:0]       w_divisor_nxt;
    logic                    r_sign1;
    logic                    w_sign1_nxt;
    logic                    r_sign2;
    logic                    w_sign2_nxt;
    logic [DoubleRegBus-1:0] r_result;
    logic [DoubleRegBus-1:0] w_result_nxt;
    logic                    r_ready;
    logic                    w_ready_nxt;

    logic                    w_accept;
    logic                    w_abort;
    logic [RegBus-1:0]       w_dividend_mag;
    logic [RegBus-1:0]       w_divisor_mag;
    logic [RegBus-1:0]       w_quotient;
    logic [RegBus-1:0]       w_remainder;

    mips_div_step u_step (
        .work      (r_work),
        .divisor   (r_divisor),
        .work_next (w_work_step)
    );

    assign w_accept = (start_i == DivStart) && !annul_i;
    assign w_abort  = annul_i || (start_i == DivStop);

    assign w_dividend_mag = (signed_div_i && opdata1_i[RegBus-1]) ? twos_neg(opdata1_i) : opdata1_i;
    assign w_divisor_mag  = (signed_div_i && opdata2_i[RegBus-1]) ? twos_neg(opdata2_i) : opdata2_i;

    // Sign flags are only ever set for DIV, so no separate signedness register is needed.
    assign w_quotient  = (r_sign1 ^ r_sign2) ? twos_neg(r_work[RegBus-1:0]) : r_work[RegBus-1:0];
    assign w_remainder = r_sign1 ? twos_neg(r_work[DoubleRegBus-1:RegBus])
                                 : r_work[DoubleRegBus-1:RegBus];

    always_comb begin
        w_state_nxt   = r_state;
        w_work_nxt    = r_work;
        w_cnt_nxt     = r_cnt;
        w_divisor_nxt = r_divisor;
        w_sign1_nxt   = r_sign1;
        w_sign2_nxt   = r_sign2;
        w_result_nxt  = r_result;
        w_ready_nxt   = r_ready;

        case (r_state)
            DivFree: begin
                w_ready_nxt  = DivResultNotReady;
                w_result_nxt = '0;
                if (w_accept) begin
                    if (opdata2_i == '0) begin
                        w_state_nxt = DivByZero;
                    end else begin
                        w_divisor_nxt = w_divisor_mag;
                        w_sign1_nxt   = signed_div_i && opdata1_i[RegBus-1];
                        w_sign2_nxt   = signed_div_i && opdata2_i[RegBus-1];
                        w_work_nxt    = {{(WorkBus-RegBus){1'b0}}, w_dividend_mag};
                        w_cnt_nxt     = '0;
                        w_state_nxt   = DivOn;
                    end
                end
            end

            DivByZero: begin
                if (w_abort) begin
                    w_state_nxt = DivFree;
                    w_work_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_result_nxt = '0;
                    w_ready_nxt  = DivResultReady;
                    w_state_nxt  = DivEnd;
                end
            end

            DivOn: begin
                if (w_abort) begin
                    w_state_nxt = DivFree;
                    w_work_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != DivIterations) begin
                    w_work_nxt = w_work_step;
                    w_cnt_nxt  = r_cnt + 6'd1;
                end else begin
                    w_result_nxt = {w_remainder, w_quotient};
                    w_ready_nxt  = DivResultReady;
                    w_state_nxt  = DivEnd;
                end
            end

            DivEnd: begin
                // Flush is deliberately ignored here; EX releases by dropping start.
                if (start_i == DivStop) begin
                    w_state_nxt  = DivFree;
                    w_ready_nxt  = DivResultNotReady;
                    w_result_nxt = '0;
                end
            end

            default: begin
                w_state_nxt = DivFree;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DivFree;
            r_work    <= '0;
            r_cnt     <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_result  <= '0;
            r_ready   <= DivResultNotReady;
        end else begin
            r_state   <= w_state_nxt;
            r_work    <= w_work_nxt;
            r_cnt     <= w_cnt_nxt;
            r_divisor <= w_divisor_nxt;
            r_sign1   <= w_sign1_nxt;
            r_sign2   <= w_sign2_nxt;
            r_result  <= w_result_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule : mips_div
`default_nettype wire
